// File: rtl/data_chk_axi_mm_burst.sv
// AXI4 read-burst checker: reads back a buffer written by the burst data generator
// and compares every beat against the incrementing byte pattern it produces.
`timescale 1ns/1ps
module data_chk_axi_mm_burst #(
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int MAX_BURST_LEN  = 16
) (
   input  logic                      ACLK,
   input  logic                      ARESETn,
   input  logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR,
   input  logic [15:0]               BYTES,
   input  logic [15:0]               REPEAT,
   input  logic                      START,
   output logic                      BUSY,
   output logic                      DONE,
   output logic                      PASS,
   output logic [15:0]               ERR_COUNT,
   output logic [AXI_ADDR_WIDTH-1:0] FIRST_ERR_ADDR,
   output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [2:0]                m_axi_arprot,
   output logic [7:0]                m_axi_arlen,
   output logic [2:0]                m_axi_arsize,
   output logic [1:0]                m_axi_arburst,
   output logic                      m_axi_arvalid,
   input  logic                      m_axi_arready,
   input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]                m_axi_rresp,
   input  logic                      m_axi_rlast,
   input  logic                      m_axi_rvalid,
   output logic                      m_axi_rready,
   output logic [1:0]                dbg_state_o
);

   localparam int BPB         = AXI_DATA_WIDTH / 8;
   localparam int BURST_BYTES = MAX_BURST_LEN * BPB;

   localparam logic [7:0]                LAST_BEAT     = 8'(MAX_BURST_LEN - 1);
   localparam logic [2:0]                ARSIZE        = 3'($clog2(BPB));
   localparam logic [AXI_ADDR_WIDTH-1:0] BEAT_STEP     = AXI_ADDR_WIDTH'(BPB);
   localparam logic [AXI_ADDR_WIDTH-1:0] BURST_STEP    = AXI_ADDR_WIDTH'(BURST_BYTES);
   localparam logic [31:0]               BURST_BYTES_W = 32'(BURST_BYTES);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ADDR   = 2'd1;
   localparam logic [1:0] S_READ   = 2'd2;
   localparam logic [1:0] S_FINISH = 2'd3;

   logic [1:0]                state_q, state_d;
   logic [AXI_ADDR_WIDTH-1:0] base_q, base_d;
   logic [15:0]               bytes_q, bytes_d;
   logic [15:0]               repeat_q, repeat_d;
   logic [15:0]               pass_cnt_q, pass_cnt_d;
   logic [31:0]               bytes_read_q, bytes_read_d;
   logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [AXI_ADDR_WIDTH-1:0] beat_addr_q, beat_addr_d;
   logic [7:0]                beat_q, beat_d;
   logic [7:0]                k_q, k_d;
   logic [15:0]               err_q, err_d;
   logic [AXI_ADDR_WIDTH-1:0] first_q, first_d;
   logic                      pass_q, pass_d;

   logic [AXI_DATA_WIDTH-1:0] exp_data;
   logic [7:0]                seed;
   logic                      burst_end;
   logic                      beat_bad;
   logic [31:0]               bytes_read_sum;
   logic [15:0]               pass_sum;

   // Handshakes: a transfer occurs on a rising ACLK edge where valid and ready are
   // both high; arvalid and rready are decoded from state only, never from the partner.
   assign BUSY           = (state_q != S_IDLE);
   assign DONE           = (state_q == S_FINISH);
   assign PASS           = pass_q;
   assign ERR_COUNT      = err_q;
   assign FIRST_ERR_ADDR = first_q;
   assign m_axi_araddr   = addr_q;
   assign m_axi_arprot   = 3'b000;
   assign m_axi_arlen    = LAST_BEAT;
   assign m_axi_arsize   = ARSIZE;
   assign m_axi_arburst  = 2'b01;
   assign m_axi_arvalid  = (state_q == S_ADDR);
   assign m_axi_rready   = (state_q == S_READ);
   assign dbg_state_o    = state_q;

   assign seed = 8'h80 + k_q;

   always_comb begin
      exp_data = '0;
      for (int i = 0; i < BPB; i++) begin
         exp_data[8*i +: 8] = seed + 8'(i);
      end
   end

   assign burst_end      = (beat_q == LAST_BEAT);
   assign beat_bad       = (m_axi_rdata != exp_data) || (m_axi_rresp != 2'b00) ||
                           (m_axi_rlast != burst_end);
   assign bytes_read_sum = bytes_read_q + BURST_BYTES_W;
   assign pass_sum       = pass_cnt_q + 16'd1;

   always_comb begin
      state_d      = state_q;
      base_d       = base_q;
      bytes_d      = bytes_q;
      repeat_d     = repeat_q;
      pass_cnt_d   = pass_cnt_q;
      bytes_read_d = bytes_read_q;
      addr_d       = addr_q;
      beat_addr_d  = beat_addr_q;
      beat_d       = beat_q;
      k_d          = k_q;
      err_d        = err_q;
      first_d      = first_q;
      pass_d       = pass_q;
      case (state_q)
         S_IDLE: begin
            if (START) begin
               base_d       = BASE_ADDR;
               bytes_d      = BYTES;
               repeat_d     = (REPEAT == 16'd0) ? 16'd1 : REPEAT;
               pass_cnt_d   = '0;
               bytes_read_d = '0;
               addr_d       = BASE_ADDR;
               beat_addr_d  = BASE_ADDR;
               k_d          = '0;
               err_d        = '0;
               first_d      = '0;
               pass_d       = 1'b0;
               state_d      = S_ADDR;
            end
         end
         S_ADDR: begin
            if (m_axi_arready) begin
               beat_d  = '0;
               state_d = S_READ;
            end
         end
         S_READ: begin
            if (m_axi_rvalid) begin
               beat_d      = beat_q + 8'd1;
               k_d         = k_q + 8'd1;
               beat_addr_d = beat_addr_q + BEAT_STEP;
               if (beat_bad) begin
                  if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                  // err_q saturates instead of wrapping, so zero means no earlier failure
                  if (err_q == 16'd0) first_d = beat_addr_q;
               end
               // rlast is only checked; the beat counter alone closes the burst
               if (burst_end) begin
                  addr_d = addr_q + BURST_STEP;
                  if (bytes_read_sum >= {16'd0, bytes_q}) begin
                     bytes_read_d = '0;
                     pass_cnt_d   = pass_sum;
                     if (pass_sum == repeat_q) begin
                        state_d = S_FINISH;
                     end else begin
                        addr_d      = base_q;
                        beat_addr_d = base_q;
                        k_d         = '0;
                        state_d     = S_ADDR;
                     end
                  end else begin
                     bytes_read_d = bytes_read_sum;
                     state_d      = S_ADDR;
                  end
               end
            end
         end
         S_FINISH: begin
            pass_d  = (err_q == 16'd0);
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         state_q      <= S_IDLE;
         base_q       <= '0;
         bytes_q      <= '0;
         repeat_q     <= '0;
         pass_cnt_q   <= '0;
         bytes_read_q <= '0;
         addr_q       <= '0;
         beat_addr_q  <= '0;
         beat_q       <= '0;
         k_q          <= '0;
         err_q        <= '0;
         first_q      <= '0;
         pass_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         base_q       <= base_d;
         bytes_q      <= bytes_d;
         repeat_q     <= repeat_d;
         pass_cnt_q   <= pass_cnt_d;
         bytes_read_q <= bytes_read_d;
         addr_q       <= addr_d;
         beat_addr_q  <= beat_addr_d;
         beat_q       <= beat_d;
         k_q          <= k_d;
         err_q        <= err_d;
         first_q      <= first_d;
         pass_q       <= pass_d;
      end
   end

endmodule

// File: tb/tb_data_chk_axi_mm_burst.sv
// Bench for data_chk_axi_mm_burst: memory responder with fault injection, a
// pattern/AR-sequence model, and directed runs with hand-computed results.
`timescale 1ns/1ps
module tb_data_chk_axi_mm_burst;

   localparam int DW  = 32;
   localparam int AW  = 32;
   localparam int BL  = 16;
   localparam int BPB = DW / 8;

   logic          ACLK = 1'b0;
   logic          ARESETn;
   logic [AW-1:0] BASE_ADDR;
   logic [15:0]   BYTES;
   logic [15:0]   REPEAT;
   logic          START;
   logic          BUSY, DONE, PASS;
   logic [15:0]   ERR_COUNT;
   logic [AW-1:0] FIRST_ERR_ADDR;
   logic [AW-1:0] m_axi_araddr;
   logic [2:0]    m_axi_arprot;
   logic [7:0]    m_axi_arlen;
   logic [2:0]    m_axi_arsize;
   logic [1:0]    m_axi_arburst;
   logic          m_axi_arvalid;
   logic          m_axi_arready = 1'b0;
   logic [DW-1:0] m_axi_rdata = '0;
   logic [1:0]    m_axi_rresp = 2'b00;
   logic          m_axi_rlast = 1'b0;
   logic          m_axi_rvalid = 1'b0;
   logic          m_axi_rready;
   logic [1:0]    dbg_state;

   data_chk_axi_mm_burst #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .MAX_BURST_LEN(BL)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn), .BASE_ADDR(BASE_ADDR), .BYTES(BYTES), .REPEAT(REPEAT),
      .START(START), .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .ERR_COUNT(ERR_COUNT),
      .FIRST_ERR_ADDR(FIRST_ERR_ADDR), .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
      .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata),
      .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
      .m_axi_rready(m_axi_rready), .dbg_state_o(dbg_state)
   );

   always #5 ACLK = ~ACLK;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Memory contents left by the generator: byte i of beat k is (0x80 + k + i) mod 256.
   function automatic logic [31:0] pat(input int k);
      logic [31:0] w;
      for (int i = 0; i < BPB; i++) w[8*i +: 8] = 8'((128 + k + i) % 256);
      return w;
   endfunction

   // model / responder state
   logic [AW-1:0] exp_ar_q[$];
   logic [AW-1:0] run_base = '0;
   logic [AW-1:0] cur_addr = '0;
   logic [AW-1:0] exp_first = '0;
   int beats_left = 0, beat_in_burst = 0, beat_global = 0, exp_beats = 0;
   int exp_err = 0, ar_seen = 0, done_cnt = 0;
   int cyc = 0, last_beat_cyc = 0;
   int max_stall = 0, stall = 0, ar_wait = 0, stray = 0;
   int fault_data = -1, fault_resp = -1, fault_nolast = -1;
   bit stray_en = 1'b0;

   // Responder and compare process: inputs change at the falling edge, so a
   // handshake decided here takes effect at the following rising edge.
   always @(negedge ACLK) begin
      int k;
      logic bad;
      cyc++;
      if (DONE === 1'b1) begin
         done_cnt++;
         chk("done_latency", cyc, last_beat_cyc + 1);
         chk("err_count", ERR_COUNT, (exp_err > 65535) ? 65535 : exp_err);
         chk("first_err_addr", FIRST_ERR_ADDR, exp_first);
         chk("ars_left", exp_ar_q.size(), 0);
         chk("beats_total", beat_global, exp_beats);
      end
      if (ARESETn !== 1'b1) begin
         beats_left    = 0;
         m_axi_arready = 1'b0;
         m_axi_rvalid  = 1'b0;
         m_axi_rlast   = 1'b0;
         if (stray_en) stray = 4;
      end else if (stray > 0) begin
         // leftover beats of an abandoned burst must not be taken
         stray--;
         m_axi_arready = 1'b0;
         m_axi_rvalid  = (stray != 0);
         m_axi_rdata   = '0;
         m_axi_rlast   = 1'b0;
         chk("rready_after_reset", m_axi_rready, 0);
      end else begin
         if (beats_left > 0) begin
            chk("no_ar_in_burst", m_axi_arvalid, 0);
            if (stall > 0) begin
               stall--;
               m_axi_rvalid = 1'b0;
            end else begin
               k = int'((cur_addr - run_base) / BPB) + beat_in_burst;
               m_axi_rvalid = 1'b1;
               m_axi_rdata  = pat(k);
               m_axi_rresp  = 2'b00;
               m_axi_rlast  = (beat_in_burst == BL - 1);
               bad = 1'b0;
               if (beat_global == fault_data)   begin m_axi_rdata = '0;    bad = 1'b1; end
               if (beat_global == fault_resp)   begin m_axi_rresp = 2'b10; bad = 1'b1; end
               if (beat_global == fault_nolast) begin m_axi_rlast = 1'b0;  bad = 1'b1; end
               if (m_axi_rready === 1'b1) begin
                  if (bad) begin
                     exp_err++;
                     if (exp_err == 1) exp_first = cur_addr + 32'(beat_in_burst * BPB);
                  end
                  beat_global++;
                  beat_in_burst++;
                  beats_left--;
                  last_beat_cyc = cyc;
                  stall = $urandom_range(0, max_stall);
               end
            end
         end else begin
            m_axi_rvalid = 1'b0;
            m_axi_rlast  = 1'b0;
            m_axi_rresp  = 2'b00;
         end
         if (beats_left == 0 && m_axi_arvalid === 1'b1) begin
            if (ar_wait > 0) begin
               ar_wait--;
               m_axi_arready = 1'b0;
            end else begin
               m_axi_arready = 1'b1;
               ar_seen++;
               chk("ar_expected", exp_ar_q.size() != 0, 1);
               if (exp_ar_q.size() != 0) chk("araddr", m_axi_araddr, exp_ar_q.pop_front());
               chk("ar_consts", {m_axi_arprot, m_axi_arlen, m_axi_arsize, m_axi_arburst},
                   {3'b000, 8'd15, 3'd2, 2'b01});
               cur_addr      = m_axi_araddr;
               beats_left    = BL;
               beat_in_burst = 0;
               ar_wait       = $urandom_range(0, max_stall);
               stall         = $urandom_range(0, max_stall);
            end
         end else begin
            m_axi_arready = 1'b0;
         end
      end
   end

   task automatic arm(input logic [AW-1:0] base, input int bytes, input int rep, input int st,
                      input int fd, input int fr, input int fn);
      int nb, np;
      nb = (bytes == 0) ? 1 : bytes / (BL * BPB);
      np = (rep == 0) ? 1 : rep;
      exp_ar_q.delete();
      for (int p = 0; p < np; p++)
         for (int b = 0; b < nb; b++) exp_ar_q.push_back(base + 32'(b * BL * BPB));
      exp_beats    = np * nb * BL;
      run_base     = base;
      beat_global  = 0;
      exp_err      = 0;
      exp_first    = '0;
      ar_seen      = 0;
      done_cnt     = 0;
      max_stall    = st;
      fault_data   = fd;
      fault_resp   = fr;
      fault_nolast = fn;
   endtask

   task automatic kick(input logic [AW-1:0] base, input int bytes, input int rep);
      @(posedge ACLK); #2;
      BASE_ADDR = base;
      BYTES     = 16'(bytes);
      REPEAT    = 16'(rep);
      START     = 1'b1;
      @(posedge ACLK); #2;
      START = 1'b0;
      chk("busy_after_start", BUSY, 1);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (DONE !== 1'b1 && n < 20000) begin
         @(negedge ACLK);
         n++;
      end
      chk("done_seen", DONE, 1);
   endtask

   task automatic finish_run();
      wait_done();
      repeat (2) @(posedge ACLK);
      #2;
      chk("done_pulses", done_cnt, 1);
      chk("busy_idle", BUSY, 0);
      chk("pass_flag", PASS, exp_err == 0);
   endtask

   initial begin
      int n;
      ARESETn = 1'b0; START = 1'b0; BASE_ADDR = '0; BYTES = '0; REPEAT = '0;
      repeat (3) @(posedge ACLK);
      #2;
      chk("rst_busy", BUSY, 0);
      chk("rst_done", DONE, 0);
      chk("rst_pass", PASS, 0);
      chk("rst_err", ERR_COUNT, 0);
      chk("rst_first", FIRST_ERR_ADDR, 0);
      chk("rst_arvalid", m_axi_arvalid, 0);
      chk("rst_rready", m_axi_rready, 0);
      chk("rst_araddr", m_axi_araddr, 0);
      ARESETn = 1'b1;

      chk("pat_k0", pat(0), 32'h83828180);
      chk("pat_k127", pat(127), 32'h020100FF);
      chk("pat_k128", pat(128), 32'h03020100);

      // clean two-burst pass
      arm(32'h1000, 128, 1, 0, -1, -1, -1);
      kick(32'h1000, 128, 1);
      finish_run();
      chk("t1_ars", ar_seen, 2);
      chk("t1_err", ERR_COUNT, 0);
      chk("t1_pass", PASS, 1);

      // bad data on beat 5
      arm(32'h1000, 128, 1, 0, 5, -1, -1);
      kick(32'h1000, 128, 1);
      finish_run();
      chk("t2_err", ERR_COUNT, 1);
      chk("t2_first", FIRST_ERR_ADDR, 32'h1014);
      chk("t2_pass", PASS, 0);

      // missing rlast on beat 15, SLVERR on beat 16
      arm(32'h1000, 128, 1, 0, -1, 16, 15);
      kick(32'h1000, 128, 1);
      finish_run();
      chk("t3_err", ERR_COUNT, 2);
      chk("t3_first", FIRST_ERR_ADDR, 32'h103C);

      // three passes with stalls; a START while busy must be ignored
      arm(32'h1000, 64, 3, 5, -1, -1, -1);
      kick(32'h1000, 64, 3);
      repeat (10) @(posedge ACLK);
      #2;
      chk("t4_busy", BUSY, 1);
      BASE_ADDR = 32'h8000;
      START     = 1'b1;
      @(posedge ACLK); #2;
      START = 1'b0;
      finish_run();
      chk("t4_ars", ar_seen, 3);
      chk("t4_err", ERR_COUNT, 0);

      // 256 beats: seed wraps through 0xFF to 0x00
      arm(32'h1000, 1024, 1, 0, -1, -1, -1);
      kick(32'h1000, 1024, 1);
      finish_run();
      chk("t5_ars", ar_seen, 16);
      chk("t5_err", ERR_COUNT, 0);

      // BYTES=0 and REPEAT=0 collapse to a single burst
      arm(32'h4000, 0, 0, 0, -1, -1, -1);
      kick(32'h4000, 0, 0);
      finish_run();
      chk("t6_ars", ar_seen, 1);

      // reset mid-burst, then a fresh run
      arm(32'h1000, 128, 1, 0, 2, -1, -1);
      kick(32'h1000, 128, 1);
      n = 0;
      while (beat_global < 8 && n < 2000) begin
         @(negedge ACLK);
         n++;
      end
      @(posedge ACLK); #2;
      chk("t7_pre_err", ERR_COUNT, 1);
      stray_en = 1'b1;
      ARESETn  = 1'b0;
      @(posedge ACLK); #2;
      chk("t7_rst_busy", BUSY, 0);
      chk("t7_rst_err", ERR_COUNT, 0);
      chk("t7_rst_first", FIRST_ERR_ADDR, 0);
      chk("t7_rst_arvalid", m_axi_arvalid, 0);
      chk("t7_rst_rready", m_axi_rready, 0);
      ARESETn = 1'b1;
      repeat (8) @(posedge ACLK);
      #2;
      stray_en = 1'b0;
      arm(32'h2000, 64, 1, 0, -1, -1, -1);
      kick(32'h2000, 64, 1);
      finish_run();
      chk("t7_err", ERR_COUNT, 0);
      chk("t7_pass", PASS, 1);

      // START held high across DONE restarts immediately
      arm(32'h3000, 64, 1, 0, -1, -1, -1);
      @(posedge ACLK); #2;
      BASE_ADDR = 32'h3000; BYTES = 16'd64; REPEAT = 16'd1; START = 1'b1;
      wait_done();
      @(posedge ACLK); #2;
      chk("t8_idle", BUSY, 0);
      arm(32'h3000, 64, 1, 0, -1, -1, -1);
      @(posedge ACLK); #2;
      chk("t8_restart", BUSY, 1);
      START = 1'b0;
      finish_run();
      chk("t8_ars", ar_seen, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
